uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares the single UART `transmitter` between two byte requesters: the received-byte echo path and the `process` result stream. Round-robin arbitration with bounded burst locking. Handshakes the transmitter through its `start`/`tx_ready` pair and flags a transmitter that never acknowledges. Sits between the requesters and `transmitter`, in the 9.6 MHz `clk` domain.

## Interface
- `DATA_W`, 8: byte width.
- `MAX_BURST`, 4: max consecutive bytes one owner sends while holding `req` (1..15).
- `ACK_TIMEOUT`, 255: cycles to wait for `tx_ready` to fall after `tx_start` (1..255).

Ports:
- `clk` in 1: system clock; rising edge only.
- `rst` in 1: reset, asynchronous, active-low.
- `req0` in 1: requester 0 (echo) has a byte; level.
- `data0` in DATA_W: requester 0 byte; stable while `req0` high and ungranted.
- `grant0` out 1: one-cycle pulse; `data0` accepted.
- `req1`, `data1`, `grant1`: same, requester 1 (process).
- `tx_ready` in 1: transmitter idle (level, synchronous to `clk`).
- `tx_start` out 1: start request to transmitter.
- `tx_data` out DATA_W: byte to transmitter.
- `busy` out 1: FSM not in IDLE.
- `owner` out 1: index of current/last granted requester.
- `err_timeout` out 1: one-cycle pulse on ack timeout.

## Operation
- States: IDLE, WAIT_ACK, WAIT_DONE.
- IDLE, arbitration when `tx_ready`=1 and any `req`:
  - If `lock` is set and `req[owner]`=1, the owner wins.
  - Else, one requester high: it wins.
  - Else, both high: `prio` wins.
- IDLE on a win: latch winner data into `tx_data`, set `owner`, pulse `grant[winner]`, go WAIT_ACK.
- IDLE with no request or `tx_ready`=0: stay; outputs hold.
- WAIT_ACK: `tx_start`=1.
  - `tx_ready`=0: go WAIT_DONE.
  - Timeout counter reaches ACK_TIMEOUT first: pulse `err_timeout`; clear `lock` and `burst_cnt`; toggle `prio` away from `owner`; go IDLE. No retry.
- WAIT_DONE: `tx_start`=0. On `tx_ready`=1:
  - `burst_cnt`++.
  - Set `lock` iff `burst_cnt` (after increment) < MAX_BURST and `req[owner]`=1. Otherwise clear `lock` and `burst_cnt`, and set `prio` = !`owner`.
  - Go IDLE.
- Requester drops `req` while locked: at the next IDLE evaluation the lock is released, `burst_cnt` cleared, and `prio` = !`owner`.
- Width rules: `burst_cnt` 4 bits; timeout counter 8 bits, cleared on WAIT_ACK entry, saturating.

## Timing
- Reset values: `tx_start`=0, `tx_data`=0, `grant0/1`=0, `busy`=0, `owner`=0, `err_timeout`=0, `prio`=0, `lock`=0, counters 0, state IDLE.
- Reset mid-operation: all of the above take effect immediately (async). `tx_start` falls without waiting for a clock.
- All outputs are registered.
- `req` high with `tx_ready`=1 in cycle N gives `grant`, `tx_start`=1 and valid `tx_data` in cycle N+1.
- `tx_data` is stable from N+1 until the next grant.
- Requester may change data or drop `req` from cycle N+2. The arbiter does not re-sample before N+3 (minimum WAIT_ACK + WAIT_DONE residency).
- Minimum grant-to-grant spacing: 3 cycles.
- `err_timeout` occurs in cycle N+1+ACK_TIMEOUT if `tx_ready` stays high. `busy`=0 the following cycle.
- Simultaneous `req0`/`req1` and `tx_ready` drop in the same IDLE cycle: no grant.

## Structure
- Shared package `uart_pkg`: state enum (IDLE/WAIT_ACK/WAIT_DONE), `DATA_W` constant, requester index constants `REQ_ECHO`=0 and `REQ_PROC`=1. `transmitter` and `process` also use this package.
- One sub-module, `ack_timer`:
  - Inputs: clear, enable.
  - Output: expired.
  - 8-bit saturating counter compared to ACK_TIMEOUT.
- FSM, arbitration, and burst logic stay in the top.
- Expected size: 150–250 lines.

## Test plan
- **Single echo:** `req0`=1, `data0`=8'h41, transmitter model idle. Expect:
  - `grant0` pulse at N+1, `tx_data`=8'h41, `tx_start` high until the model drops `tx_ready`.
  - `owner`=0; `busy` back to 0 after `tx_ready` returns.
- **Contention from reset:** both `req` high, `data0`=8'h11, `data1`=8'h22, each requester drops `req` after one grant. Expect 8'h11 first, then 8'h22 (`prio` toggled).
- **Burst cap:** `req1` held high with bytes 8'hA0..8'hA5, `req0` high throughout, MAX_BURST=4. Expect A0–A3 from requester 1, then a `data0` byte, then A4.
- **Ack timeout:** `tx_ready` stuck high, ACK_TIMEOUT=10. Expect:
  - `err_timeout` pulse exactly 10 cycles after `tx_start` rises.
  - `tx_start`=0, FSM back in IDLE.
  - Next grant goes to the other requester if both request.
- **Async reset in WAIT_ACK:** assert `rst`=0 mid-cycle. Expect `tx_start`, `busy` and `tx_data` to be 0 before the next clock edge. After release, the first contention goes to requester 0.
- **Blocked transmitter:** `tx_ready`=0 for 20 cycles with `req0` high. Expect no grant during those cycles; grant in the cycle after `tx_ready` rises.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter FSM states, byte width and requester indices.
package uart_pkg;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned REQ_ECHO = 0;
  localparam int unsigned REQ_PROC = 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ACK  = 2'd1,
    WAIT_DONE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/ack_timer.sv
// Saturating cycle counter that flags when the transmitter has not acknowledged in time.
module ack_timer #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = 8;
  // expired is registered, so it must rise one count early to land on the timeout cycle
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(ACK_TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             expired_q, expired_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    expired_d = (cnt_d >= LIMIT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      expired_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      expired_q <= expired_d;
    end
  end

  assign expired = expired_q;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter with burst locking that feeds the shared UART transmitter.
module uart_tx_arbiter #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned MAX_BURST   = 4,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [DATA_W-1:0] data0,
  output logic              grant0,
  input  logic              req1,
  input  logic [DATA_W-1:0] data1,
  output logic              grant1,
  input  logic              tx_ready,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic              owner,
  output logic              err_timeout
);

  import uart_pkg::*;

  localparam int unsigned BURST_W = 4;
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);

  arb_state_e         state_q, state_d;
  logic [DATA_W-1:0]  tx_data_q, tx_data_d;
  logic               tx_start_q, tx_start_d;
  logic               grant0_q, grant0_d;
  logic               grant1_q, grant1_d;
  logic               busy_q, busy_d;
  logic               owner_q, owner_d;
  logic               err_q, err_d;
  logic               prio_q, prio_d;
  logic               lock_q, lock_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [BURST_W-1:0] burst_inc;
  logic [1:0]         req_c;
  logic               lock_live;
  logic               win_c;
  logic               timer_clear;
  logic               timer_en;
  logic               timer_expired;

  assign req_c     = {req1, req0};
  assign burst_inc = burst_q + BURST_W'(1);
  assign timer_en  = (state_q == WAIT_ACK);

  ack_timer #(
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) u_ack_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear),
    .enable  (timer_en),
    .expired (timer_expired)
  );

  always_comb begin
    state_d     = state_q;
    tx_start_d  = tx_start_q;
    tx_data_d   = tx_data_q;
    grant0_d    = 1'b0;
    grant1_d    = 1'b0;
    owner_d     = owner_q;
    err_d       = 1'b0;
    prio_d      = prio_q;
    lock_d      = lock_q;
    burst_d     = burst_q;
    timer_clear = 1'b0;
    lock_live   = lock_q;
    win_c       = prio_q;

    case (state_q)
      IDLE: begin
        // owner let go of req while locked: hand the turn to the other side
        if (lock_q && !req_c[owner_q]) begin
          lock_live = 1'b0;
          lock_d    = 1'b0;
          burst_d   = '0;
          prio_d    = !owner_q;
        end
        if (tx_ready && (req0 || req1)) begin
          if (lock_live)          win_c = owner_q;
          else if (req0 && req1)  win_c = prio_q;
          else                    win_c = req1;
          tx_data_d   = win_c ? data1 : data0;
          owner_d     = win_c;
          grant0_d    = (win_c == 1'(REQ_ECHO));
          grant1_d    = (win_c == 1'(REQ_PROC));
          tx_start_d  = 1'b1;
          timer_clear = 1'b1;
          state_d     = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (!tx_ready) begin
          tx_start_d = 1'b0;
          state_d    = WAIT_DONE;
        end else if (timer_expired) begin
          err_d      = 1'b1;
          tx_start_d = 1'b0;
          lock_d     = 1'b0;
          burst_d    = '0;
          prio_d     = !owner_q;
          state_d    = IDLE;
        end
      end
      WAIT_DONE: begin
        if (tx_ready) begin
          if ((burst_inc < BURST_MAX) && req_c[owner_q]) begin
            lock_d  = 1'b1;
            burst_d = burst_inc;
          end else begin
            lock_d  = 1'b0;
            burst_d = '0;
            prio_d  = !owner_q;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      grant0_q   <= 1'b0;
      grant1_q   <= 1'b0;
      busy_q     <= 1'b0;
      owner_q    <= 1'b0;
      err_q      <= 1'b0;
      prio_q     <= 1'b0;
      lock_q     <= 1'b0;
      burst_q    <= '0;
    end else begin
      state_q    <= state_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      grant0_q   <= grant0_d;
      grant1_q   <= grant1_d;
      busy_q     <= busy_d;
      owner_q    <= owner_d;
      err_q      <= err_d;
      prio_q     <= prio_d;
      lock_q     <= lock_d;
      burst_q    <= burst_d;
    end
  end

  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign grant0      = grant0_q;
  assign grant1      = grant1_q;
  assign busy        = busy_q;
  assign owner       = owner_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios with literal expectations, then random traffic
// against a transaction-level model of the arbitration rules.
module tb_uart_tx_arbiter;

  localparam int T_ACK = 10;
  localparam int MB    = 4;

  logic       clk;
  logic       rst;
  logic [1:0] req_v;
  logic [7:0] dat_v [2];
  logic       tx_ready;
  logic       grant0, grant1, tx_start, busy, owner, err_timeout;
  logic [7:0] tx_data;

  int n_vec;
  int n_bad;

  // model: is a byte in flight, has the transmitter taken it, who is favoured next
  bit   m_busy, m_acked, m_keep;
  int   m_owner, m_favor, m_run, m_wait, m_w;
  logic e_start, e_g0, e_g1, e_busy, e_owner, e_err;
  logic [7:0] e_data;

  // stimulus control
  int tx_mode;   // 0 behavioural transmitter, 1 stuck ready, 2 held busy
  bit tx_rand, auto_req;
  int low_cnt, drop_cnt;
  bit gseen [2];

  uart_tx_arbiter #(
    .DATA_W      (8),
    .MAX_BURST   (MB),
    .ACK_TIMEOUT (T_ACK)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req0        (req_v[0]),
    .data0       (dat_v[0]),
    .grant0      (grant0),
    .req1        (req_v[1]),
    .data1       (dat_v[1]),
    .grant1      (grant1),
    .tx_ready    (tx_ready),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .busy        (busy),
    .owner       (owner),
    .err_timeout (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_busy = 0; m_acked = 0; m_keep = 0;
    m_owner = 0; m_favor = 0; m_run = 0; m_wait = 0;
    e_start = 0; e_data = 8'h00; e_g0 = 0; e_g1 = 0;
    e_busy = 0; e_owner = 0; e_err = 0;
  endtask

  // One clock of the arbitration rules, using inputs as seen at the edge.
  task automatic model_update();
    e_g0 = 0; e_g1 = 0; e_err = 0;
    if (!m_busy) begin
      if (m_keep && !req_v[m_owner]) begin
        m_keep = 0; m_run = 0; m_favor = 1 - m_owner;
      end
      if (tx_ready && req_v != 2'b00) begin
        if (m_keep)              m_w = m_owner;
        else if (req_v == 2'b11) m_w = m_favor;
        else                     m_w = (req_v == 2'b10) ? 1 : 0;
        m_owner = m_w;
        e_data  = dat_v[m_w];
        e_g0    = (m_w == 0);
        e_g1    = (m_w == 1);
        e_start = 1;
        m_busy  = 1; m_acked = 0; m_wait = 1;
      end
    end else if (!m_acked) begin
      if (!tx_ready) begin
        m_acked = 1; e_start = 0;
      end else if (m_wait >= T_ACK) begin
        e_err = 1; e_start = 0; m_busy = 0;
        m_keep = 0; m_run = 0; m_favor = 1 - m_owner;
      end else begin
        m_wait++;
      end
    end else if (tx_ready) begin
      m_run++;
      if (m_run < MB && req_v[m_owner]) m_keep = 1;
      else begin
        m_keep = 0; m_run = 0; m_favor = 1 - m_owner;
      end
      m_busy = 0;
    end
    e_busy  = m_busy;
    e_owner = m_owner[0];
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic check_model();
    n_vec++;
    if ({tx_start, tx_data, grant0, grant1, busy, owner, err_timeout} !==
        {e_start, e_data, e_g0, e_g1, e_busy, e_owner, e_err}) begin
      n_bad++;
      $display("FAIL model_cmp at %0t: dut start=%b data=%02h g0=%b g1=%b busy=%b owner=%b err=%b, expected start=%b data=%02h g0=%b g1=%b busy=%b owner=%b err=%b",
               $time, tx_start, tx_data, grant0, grant1, busy, owner, err_timeout,
               e_start, e_data, e_g0, e_g1, e_busy, e_owner, e_err);
    end
  endtask

  task automatic drive_tx();
    case (tx_mode)
      1: tx_ready = 1'b1;
      2: tx_ready = 1'b0;
      default: begin
        if (!tx_ready) begin
          if (low_cnt <= 1) tx_ready = 1'b1;
          else low_cnt--;
        end else begin
          if (drop_cnt < 0 && tx_start)
            drop_cnt = !tx_rand ? 0 :
                       ($urandom_range(0, 15) == 0) ? 12 : int'($urandom_range(0, 2));
          if (drop_cnt == 0) begin
            tx_ready = 1'b0;
            drop_cnt = -1;
            low_cnt  = tx_rand ? int'($urandom_range(1, 3)) : 1;
          end else if (drop_cnt > 0) begin
            drop_cnt--;
          end else if (tx_rand && $urandom_range(0, 9) == 0) begin
            tx_ready = 1'b0;
            low_cnt  = int'($urandom_range(1, 4));
          end
        end
      end
    endcase
  endtask

  task automatic drive_req();
    for (int i = 0; i < 2; i++) begin
      if (gseen[i]) begin
        gseen[i] = 0;
        req_v[i] = ($urandom_range(0, 3) != 0);
        dat_v[i] = 8'($urandom);
      end else if ((i == 0) ? grant0 : grant1) begin
        gseen[i] = 1;
      end else if (!req_v[i] && $urandom_range(0, 2) == 0) begin
        req_v[i] = 1'b1;
        dat_v[i] = 8'($urandom);
      end
    end
  endtask

  // Advance one clock: update the model at the edge, compare after it, then drive.
  task automatic step();
    @(posedge clk);
    if (!rst) model_reset();
    else      model_update();
    #2;
    if (rst) check_model();
    drive_tx();
    if (auto_req) drive_req();
  endtask

  task automatic wait_grant(input int budget, output int cyc);
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (!(grant0 || grant1) && cyc < budget);
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    do begin
      step();
      c++;
    end while (busy && c < 20);
    check("idle_return", 32'(busy), 32'd0);
  endtask

  initial begin
    int         c, k1, ng;
    logic       g;
    logic [7:0] got   [6];
    logic [7:0] exp_b [6];

    n_vec = 0; n_bad = 0;
    tx_mode = 0; tx_rand = 0; auto_req = 0;
    low_cnt = 0; drop_cnt = -1;
    gseen[0] = 0; gseen[1] = 0;
    rst = 1'b0; req_v = 2'b00; dat_v[0] = 8'h00; dat_v[1] = 8'h00; tx_ready = 1'b1;
    model_reset();

    repeat (3) step();
    check("reset_tx_start", 32'(tx_start), 32'd0);
    check("reset_tx_data", 32'(tx_data), 32'd0);
    check("reset_flags", 32'({busy, owner, grant0, grant1, err_timeout}), 32'd0);
    rst = 1'b1;
    step();

    // contention straight out of reset
    req_v = 2'b11; dat_v[0] = 8'h11; dat_v[1] = 8'h22;
    wait_grant(8, c);
    check("cont_first_grant", 32'({grant1, grant0}), 32'd1);
    check("cont_first_data", 32'(tx_data), 32'h11);
    step(); req_v[0] = 1'b0;
    wait_grant(12, c);
    check("cont_second_grant", 32'({grant1, grant0}), 32'd2);
    check("cont_second_data", 32'(tx_data), 32'h22);
    step(); req_v[1] = 1'b0;
    wait_idle();

    // single echo byte
    req_v[0] = 1'b1; dat_v[0] = 8'h41;
    wait_grant(8, c);
    check("echo_latency", 32'(c), 32'd1);
    check("echo_grant", 32'({grant1, grant0}), 32'd1);
    check("echo_data", 32'(tx_data), 32'h41);
    check("echo_start", 32'(tx_start), 32'd1);
    step(); req_v[0] = 1'b0;
    wait_idle();
    check("echo_owner", 32'(owner), 32'd0);

    // burst cap on requester 1 with requester 0 waiting
    exp_b[0] = 8'hA0; exp_b[1] = 8'hA1; exp_b[2] = 8'hA2;
    exp_b[3] = 8'hA3; exp_b[4] = 8'h5C; exp_b[5] = 8'hA4;
    req_v[1] = 1'b1; dat_v[1] = 8'hA0; k1 = 0;
    for (int k = 0; k < 6; k++) begin
      wait_grant(12, c);
      got[k] = tx_data;
      g = grant1;
      step();
      if (g) begin
        k1++;
        dat_v[1] = 8'(8'hA0 + k1);
      end else begin
        req_v[0] = 1'b0;
      end
      if (k == 0) begin
        req_v[0] = 1'b1; dat_v[0] = 8'h5C;
      end
    end
    req_v[1] = 1'b0;
    for (int k = 0; k < 6; k++) check("burst_order", 32'(got[k]), 32'(exp_b[k]));
    wait_idle();

    // transmitter never acknowledges
    tx_mode = 1; req_v[0] = 1'b1; dat_v[0] = 8'h77;
    wait_grant(8, c);
    check("timeout_grant", 32'({grant1, grant0}), 32'd1);
    c = 0;
    do begin
      step();
      c++;
    end while (!err_timeout && c < 30);
    check("timeout_cycles", 32'(c), 32'(T_ACK));
    check("timeout_start_low", 32'(tx_start), 32'd0);
    req_v[0] = 1'b0;
    step();
    check("timeout_busy_after", 32'(busy), 32'd0);
    tx_mode = 0; req_v = 2'b11; dat_v[0] = 8'h01; dat_v[1] = 8'h02;
    wait_grant(8, c);
    check("timeout_next_owner", 32'({grant1, grant0}), 32'd2);
    step(); req_v = 2'b00;
    wait_idle();

    // asynchronous reset while waiting for the acknowledge
    tx_mode = 1; req_v[0] = 1'b1; dat_v[0] = 8'h9A;
    wait_grant(8, c);
    check("arst_pre_start", 32'(tx_start), 32'd1);
    #1 rst = 1'b0;
    model_reset();
    #1;
    check("arst_tx_start", 32'(tx_start), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_tx_data", 32'(tx_data), 32'd0);
    req_v = 2'b00; tx_mode = 0;
    step(); step();
    rst = 1'b1; req_v = 2'b11; dat_v[0] = 8'h03; dat_v[1] = 8'h04;
    wait_grant(8, c);
    check("arst_first_grant", 32'({grant1, grant0}), 32'd1);
    step(); req_v = 2'b00;
    wait_idle();

    // transmitter held busy
    tx_mode = 2;
    step();
    req_v[0] = 1'b1; dat_v[0] = 8'h55; ng = 0;
    repeat (20) begin
      step();
      if (grant0 || grant1) ng++;
    end
    check("blocked_no_grant", 32'(ng), 32'd0);
    tx_mode = 0; tx_ready = 1'b1; low_cnt = 0;
    wait_grant(4, c);
    check("blocked_release_latency", 32'(c), 32'd1);
    check("blocked_release_grant", 32'({grant1, grant0}), 32'd1);
    step(); req_v = 2'b00;
    wait_idle();

    // random traffic against the model
    tx_rand = 1; auto_req = 1;
    repeat (4000) step();
    auto_req = 0; tx_rand = 0; req_v = 2'b00;
    repeat (40) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
